// File: rtl/insn_fetch_buf.sv
// Instruction fetch buffer: issues in-order word fetches into a DEPTH-entry queue
// and presents the oldest filled entry to decode; redirects flush and drain stale responses.
module insn_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_q_insn,
  output logic [31:0] id_q_pc
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      ent_pc_q   [DEPTH];
  logic [31:0]      ent_pc_d   [DEPTH];
  logic [31:0]      ent_insn_q [DEPTH];
  logic [31:0]      ent_insn_d [DEPTH];
  logic [31:0]      id_pc_hold_q, id_pc_hold_d;

  logic req_fire;
  logic pop;

  // A full buffer never issues, even when the head pops in the same cycle.
  assign imem_req_valid = !rst_i && !redirect_valid &&
                          (alloc_cnt_q < DEPTH_C) && (outstanding_q < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid  = !rst_i && (alloc_cnt_q != '0) && filled_q[head_q];
  assign id_q_insn = id_valid ? ent_insn_q[head_q] : NOP;
  assign id_q_pc   = rst_i ? 32'h0 : (id_valid ? ent_pc_q[head_q] : id_pc_hold_q);
  assign pop       = id_valid && id_ready;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fill_d        = fill_q;
    alloc_cnt_d   = alloc_cnt_q;
    outstanding_d = outstanding_q;
    discard_cnt_d = discard_cnt_q;
    filled_d      = filled_q;
    ent_pc_d      = ent_pc_q;
    ent_insn_d    = ent_insn_q;
    id_pc_hold_d  = id_q_pc;

    if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be drained.
      filled_d      = '0;
      head_d        = '0;
      tail_d        = '0;
      fill_d        = '0;
      alloc_cnt_d   = '0;
      fetch_pc_d    = redirect_pc;
      outstanding_d = outstanding_q - CNT_W'(imem_rsp_valid);
      discard_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        ent_pc_d[tail_q] = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_W'(1);
        fetch_pc_d       = fetch_pc_q + 32'd4;
      end
      // Fill follows allocation so a same-cycle fill of the new tail wins.
      if (imem_rsp_valid) begin
        if (discard_cnt_q != '0) begin
          discard_cnt_d = discard_cnt_q - CNT_W'(1);
        end else begin
          ent_insn_d[fill_q] = imem_rsp_data;
          filled_d[fill_q]   = 1'b1;
          fill_d             = fill_q + PTR_W'(1);
        end
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      alloc_cnt_d   = alloc_cnt_q + CNT_W'(req_fire) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      alloc_cnt_q   <= '0;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      filled_q      <= '0;
      id_pc_hold_q  <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fill_q        <= fill_d;
      alloc_cnt_q   <= alloc_cnt_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      filled_q      <= filled_d;
      id_pc_hold_q  <= id_pc_hold_d;
    end
  end

  // NOTE: entry payloads are left unreset; the filled bits alone gate their use.
  always_ff @(posedge clk_i) begin
    ent_pc_q   <= ent_pc_d;
    ent_insn_q <= ent_insn_d;
  end

  a_rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rsp_valid |-> (outstanding_q != '0));

  a_counts_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    (outstanding_q <= DEPTH_C) && (alloc_cnt_q <= DEPTH_C) && (discard_cnt_q <= DEPTH_C));

endmodule

// File: tb/tb_insn_fetch_buf.sv
// Self-checking bench for insn_fetch_buf: directed scenarios plus a randomized run
// compared against a queue-based reference model and an in-order memory model.
module tb_insn_fetch_buf;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_q_insn;
  logic [31:0] id_q_pc;

  insn_fetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_q_insn      (id_q_insn),
    .id_q_pc        (id_q_pc)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; logic [31:0] insn; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  // Reference model: fetch PC, the buffer as a queue, in-flight and to-drop counts.
  ent_t        q[$];
  pend_t       pend[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_last_pc = 32'h0;
  int          m_out = 0;
  int          m_disc = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          have_cycle = 0;

  logic        exp_req_valid, exp_id_valid;
  logic [31:0] exp_req_addr, exp_id_insn, exp_id_pc;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Applies the effect of the cycle just sampled (inputs are still held).
  task automatic commit();
    bit  sf, rf, pf, done;
    have_cycle = 0;
    if (rst_i) begin
      m_pc = RESET_PC; q.delete(); pend.delete();
      m_out = 0; m_disc = 0; m_last_pc = 32'h0;
      return;
    end
    sf = imem_rsp_valid;
    if (sf) void'(pend.pop_front());
    if (redirect_valid) begin
      m_out  = m_out - int'(sf);
      m_disc = m_out;
      q.delete();
      m_pc   = redirect_pc;
    end else begin
      rf = exp_req_valid && imem_req_ready;
      pf = exp_id_valid && id_ready;
      if (sf) begin
        if (m_disc > 0) m_disc--;
        else begin
          done = 0;
          for (int i = 0; i < q.size(); i++)
            if (!done && !q[i].filled) begin
              q[i].insn = imem_rsp_data; q[i].filled = 1; done = 1;
            end
        end
        m_out--;
      end
      if (pf) void'(q.pop_front());
      if (rf) begin
        q.push_back('{m_pc, 32'h0, 1'b0});
        pend.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min))});
        m_pc  = m_pc + 32'd4;
        m_out++;
      end
    end
    m_last_pc = exp_id_pc;
  endtask

  task automatic settle();
    if (have_cycle) commit();
  endtask

  // Drives one cycle of inputs at the falling edge and computes expected outputs.
  task automatic tick(input bit rst, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input bit idr);
    settle();
    @(negedge clk_i);
    cyc++;
    rst_i = rst; imem_req_ready = rdy; redirect_valid = redir;
    redirect_pc = rpc; id_ready = idr;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    exp_req_valid = !rst && !redir && (q.size() < DEPTH) && (m_out < DEPTH);
    exp_req_addr  = m_pc;
    exp_id_valid  = !rst && (q.size() > 0) && q[0].filled;
    exp_id_insn   = exp_id_valid ? q[0].insn : NOP;
    exp_id_pc     = rst ? 32'h0 : (exp_id_valid ? q[0].pc : m_last_pc);
    have_cycle = 1;
    #1;
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 32'h0, 0);
    tick(1, 0, 0, 32'h0, 0);
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1;
    do_reset();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
    n_cmp++; if (id_q_insn !== NOP) begin n_fail++; $display("FAIL rst_id_insn got=%h exp=%h", id_q_insn, NOP); end
    n_cmp++; if (id_q_pc !== 32'h0) begin n_fail++; $display("FAIL rst_id_pc got=%h exp=0", id_q_pc); end
    tick(0, 1, 0, 32'h0, 0);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got=%b exp=1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
  endtask

  task automatic test_streaming();
    int got = 0;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 30 && got < 3; i++) begin
      tick(0, 1, 0, 32'h0, 1);
      if (id_valid) begin
        n_cmp++; if (id_q_pc !== 32'(4 * got)) begin n_fail++; $display("FAIL stream_pc got=%h exp=%h", id_q_pc, 32'(4 * got)); end
        n_cmp++; if (id_q_insn !== mem_word(32'(4 * got))) begin n_fail++; $display("FAIL stream_insn got=%h exp=%h", id_q_insn, mem_word(32'(4 * got))); end
        got++;
      end else begin
        n_cmp++; if (id_q_insn !== NOP) begin n_fail++; $display("FAIL stream_nop got=%h exp=%h", id_q_insn, NOP); end
      end
    end
    n_cmp++; if (got != 3) begin n_fail++; $display("FAIL stream_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_full_stall();
    int pops = 0;
    bit seen_req = 0;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 32'h0, 0);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_id_valid got=%b exp=1", id_valid); end
    n_cmp++; if (id_q_pc !== 32'h0) begin n_fail++; $display("FAIL stall_id_pc got=%h exp=0", id_q_pc); end
    n_cmp++; if (id_q_insn !== mem_word(32'h0)) begin n_fail++; $display("FAIL stall_id_insn got=%h exp=%h", id_q_insn, mem_word(32'h0)); end
    for (int i = 0; i < 20 && (pops < 2 || !seen_req); i++) begin
      tick(0, 1, 0, 32'h0, 1);
      if (id_valid && pops < 2) begin
        n_cmp++; if (id_q_pc !== 32'(4 * pops)) begin n_fail++; $display("FAIL release_pc got=%h exp=%h", id_q_pc, 32'(4 * pops)); end
        pops++;
      end
      if (imem_req_valid && !seen_req) begin
        n_cmp++; if (imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL resume_addr got=%h exp=8", imem_req_addr); end
        seen_req = 1;
      end
    end
    n_cmp++; if (pops != 2 || !seen_req) begin n_fail++; $display("FAIL release_timeout got=%0d/%0d exp=2/1", pops, seen_req); end
  endtask

  task automatic test_redirect();
    bit seen = 0;
    lat_min = 4; lat_max = 4;
    do_reset();
    tick(0, 1, 0, 32'h0, 1);
    tick(0, 1, 0, 32'h0, 1);
    tick(0, 1, 1, 32'h100, 1);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_valid got=%b exp=0", imem_req_valid); end
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(0, 1, 0, 32'h0, 1);
      if (!id_valid) begin
        n_cmp++; if (id_q_insn !== NOP) begin n_fail++; $display("FAIL redir_nop got=%h exp=%h", id_q_insn, NOP); end
      end else begin
        n_cmp++; if (id_q_pc !== 32'h100) begin n_fail++; $display("FAIL redir_pc got=%h exp=100", id_q_pc); end
        n_cmp++; if (id_q_insn !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_insn got=%h exp=%h", id_q_insn, mem_word(32'h100)); end
        seen = 1;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL redir_timeout got=0 exp=1"); end
  endtask

  task automatic test_redirect_rsp_pop();
    bit found = 0;
    int out_before;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      if (q.size() > 0 && q[0].filled && pend.size() > 0 && pend[0].due <= cyc + 1) found = 1;
      else tick(0, 1, 0, 32'h0, 1);
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rpp_setup_timeout got=0 exp=1"); end
    out_before = m_out;
    tick(0, 1, 1, 32'h200, 1);
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rpp_pop_offered got=%b exp=1", id_valid); end
    tick(0, 0, 0, 32'h0, 1);
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rpp_empty_valid got=%b exp=0", id_valid); end
    n_cmp++; if (id_q_insn !== NOP) begin n_fail++; $display("FAIL rpp_empty_insn got=%h exp=%h", id_q_insn, NOP); end
    n_cmp++; if (dut.alloc_cnt_q !== '0) begin n_fail++; $display("FAIL rpp_alloc got=%0d exp=0", dut.alloc_cnt_q); end
    n_cmp++; if (int'(dut.discard_cnt_q) !== out_before - 1) begin n_fail++; $display("FAIL rpp_discard got=%0d exp=%0d", dut.discard_cnt_q, out_before - 1); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addrs [2];
    int nreq = 0;
    int npop = 0;
    exp_addrs[0] = 32'hFFFF_FFFC;
    exp_addrs[1] = 32'h0000_0000;
    lat_min = 1; lat_max = 1;
    do_reset();
    tick(0, 1, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 20 && (nreq < 2 || npop < 2); i++) begin
      tick(0, 1, 0, 32'h0, 1);
      if (imem_req_valid && nreq < 2) begin
        n_cmp++; if (imem_req_addr !== exp_addrs[nreq]) begin n_fail++; $display("FAIL wrap_req got=%h exp=%h", imem_req_addr, exp_addrs[nreq]); end
        nreq++;
      end
      if (id_valid && npop < 2) begin
        n_cmp++; if (id_q_pc !== exp_addrs[npop]) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", id_q_pc, exp_addrs[npop]); end
        npop++;
      end
    end
    n_cmp++; if (nreq != 2 || npop != 2) begin n_fail++; $display("FAIL wrap_timeout got=%0d/%0d exp=2/2", nreq, npop); end
  endtask

  task automatic test_reset_midflight();
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 32'h0, 1);
    n_cmp++; if (m_out != 2) begin n_fail++; $display("FAIL mid_setup got=%0d exp=2", m_out); end
    tick(1, 1, 0, 32'h0, 1);
    tick(0, 1, 0, 32'h0, 1);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_req_valid got=%b exp=1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL mid_req_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_id_valid got=%b exp=0", id_valid); end
    n_cmp++; if (id_q_pc !== 32'h0) begin n_fail++; $display("FAIL mid_id_pc got=%h exp=0", id_q_pc); end
    n_cmp++; if (id_q_insn !== NOP) begin n_fail++; $display("FAIL mid_id_insn got=%h exp=%h", id_q_insn, NOP); end
  endtask

  task automatic test_random();
    bit          r_rst, r_redir;
    logic [31:0] r_pc;
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_rst   = ($urandom_range(199, 0) == 0);
      r_redir = ($urandom_range(19, 0) == 0);
      r_pc    = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      if ($urandom_range(7, 0) == 0) r_pc = 32'hFFFF_FFF8;
      tick(r_rst, $urandom_range(9, 0) < 7, r_redir, r_pc, $urandom_range(9, 0) < 7);
      n_cmp++; if (imem_req_valid !== exp_req_valid) begin n_fail++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid); end
      if (!r_rst) begin
        n_cmp++; if (imem_req_addr !== exp_req_addr) begin n_fail++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_addr); end
      end
      n_cmp++; if (id_valid !== exp_id_valid) begin n_fail++; $display("FAIL rnd_id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, exp_id_valid); end
      n_cmp++; if (id_q_insn !== exp_id_insn) begin n_fail++; $display("FAIL rnd_id_insn cyc=%0d got=%h exp=%h", cyc, id_q_insn, exp_id_insn); end
      n_cmp++; if (id_q_pc !== exp_id_pc) begin n_fail++; $display("FAIL rnd_id_pc cyc=%0d got=%h exp=%h", cyc, id_q_pc, exp_id_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_full_stall();
    test_redirect();
    test_redirect_rsp_pop();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
